// File: rtl/write_pointer_full.sv
// Write-domain half of the async FIFO: binary/Gray write pointers, read-pointer
// synchroniser, and registered full / almost-full / level / sticky overflow flags.
`timescale 1ns/1ps
module write_pointer_full #(
   parameter int address_size      = 3,
   parameter int almost_full_level = 6
) (
   input  logic                    write_clk,
   input  logic                    write_reset_n,
   input  logic                    write_increment,
   input  logic [address_size:0]   read_pointer_async,
   output logic [address_size-1:0] write_address,
   output logic [address_size:0]   write_pointer,
   output logic                    write_full,
   output logic                    write_almost_full,
   output logic [address_size:0]   write_level,
   output logic                    write_overflow
);
   localparam int ptr_w = address_size + 1;
   // Full means the write pointer is exactly one lap ahead: top two Gray bits inverted.
   localparam logic [ptr_w-1:0] full_mask = ptr_w'(3) << (address_size - 1);
   localparam logic [ptr_w-1:0] af_level  = ptr_w'(almost_full_level);

   logic [ptr_w-1:0] bin;
   logic [ptr_w-1:0] bin_next;
   logic [ptr_w-1:0] gray_next;
   logic [ptr_w-1:0] rq1;
   logic [ptr_w-1:0] rq2;
   logic [ptr_w-1:0] rq2_bin;
   logic [ptr_w-1:0] level_next;
   logic             inc_ok;
   logic             full_next;

   always_ff @(posedge write_clk or negedge write_reset_n) begin
      if (!write_reset_n) begin
         rq1 <= '0;
         rq2 <= '0;
      end else begin
         rq1 <= read_pointer_async;
         rq2 <= rq1;
      end
   end

   always_comb begin
      rq2_bin    = '0;
      inc_ok     = write_increment & ~write_full;
      bin_next   = bin + ptr_w'(inc_ok);
      gray_next  = (bin_next >> 1) ^ bin_next;
      for (int i = 0; i < ptr_w; i++) begin
         rq2_bin[i] = ^(rq2 >> i);
      end
      level_next = bin_next - rq2_bin;
      full_next  = (gray_next == (rq2 ^ full_mask));
   end

   always_ff @(posedge write_clk or negedge write_reset_n) begin
      if (!write_reset_n) begin
         bin               <= '0;
         write_pointer     <= '0;
         write_full        <= 1'b0;
         write_almost_full <= 1'b0;
         write_level       <= '0;
         write_overflow    <= 1'b0;
      end else begin
         bin               <= bin_next;
         write_pointer     <= gray_next;
         write_full        <= full_next;
         write_almost_full <= (level_next >= af_level);
         write_level       <= level_next;
         write_overflow    <= write_overflow | (write_increment & write_full);
      end
   end

   assign write_address = bin[address_size-1:0];

endmodule
